// File: rtl/usbfs_endp_rx_buf.sv
// USB FS OUT-endpoint receive buffer: drains accepted packets from the packet store into a byte FIFO
// and streams them out with last/zlp markers. Optional zero-length-packet beats: USBFS_ENDP_RX_BUF_ZLP_EN.
module usbfs_endp_rx_buf #(
    parameter int MAX_PKT = 8,
    parameter int N_PKT   = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_ready,
    output logic                        o_valid,
    output logic [7:0]                  o_data,
    output logic                        o_last,
    output logic                        o_zlp,
    input  logic                        i_halt,
    input  logic                        i_unhalt,
    output logic                        o_erStall,
    output logic                        o_erReady,
    input  logic                        i_erValid,
    input  logic [$clog2(MAX_PKT):0]    i_erRdNBytes,
    output logic                        o_erRdEn,
    output logic [$clog2(MAX_PKT)-1:0]  o_erRdIdx,
    input  logic [7:0]                  i_erRdByte
);
    localparam int DEPTH = N_PKT * MAX_PKT;
    localparam int IDX_W = $clog2(MAX_PKT);
    localparam int NB_W  = IDX_W + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef USBFS_ENDP_RX_BUF_ZLP_EN
    localparam int ENT_W = 10;
`else
    localparam int ENT_W = 9;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_LAST} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   rd_idx_reg, rd_idx_next;
    logic [NB_W-1:0]    n_reg, n_next;
    logic               halt_reg;
    logic               rd_en_d_reg, last_d_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic               er_ready, er_accepted, rd_en, is_last_idx;
    logic               push, pop;
    logic [ENT_W-1:0]   push_entry, head;

    // Accept only when a whole maximum-size packet is guaranteed to fit.
    assign er_ready    = (state_reg == ST_IDLE) && !halt_reg && (cnt_reg <= CNT_W'(DEPTH - MAX_PKT));
    assign er_accepted = er_ready && i_erValid;
    assign is_last_idx = ({1'b0, rd_idx_reg} == (n_reg - NB_W'(1)));

    always_comb begin
        state_next  = state_reg;
        rd_idx_next = rd_idx_reg;
        n_next      = n_reg;
        rd_en       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (er_accepted) begin
                    n_next      = i_erRdNBytes;
                    rd_idx_next = '0;
                    if (i_erRdNBytes != '0) begin
                        state_next = ST_READ;
                    end else begin
`ifdef USBFS_ENDP_RX_BUF_ZLP_EN
                        state_next = ST_LAST;
`else
                        state_next = ST_IDLE;
`endif
                    end
                end
            end
            ST_READ: begin
                rd_en       = 1'b1;
                rd_idx_next = rd_idx_reg + IDX_W'(1);
                if (is_last_idx) begin
                    state_next = ST_LAST;
                end
            end
            ST_LAST: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            rd_idx_reg  <= '0;
            n_reg       <= '0;
            halt_reg    <= 1'b0;
            rd_en_d_reg <= 1'b0;
            last_d_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_idx_reg  <= rd_idx_next;
            n_reg       <= n_next;
            halt_reg    <= i_halt | (halt_reg & ~i_unhalt);
            // Store read data arrives one cycle after the enable, so the push is delayed to match.
            rd_en_d_reg <= rd_en;
            last_d_reg  <= rd_en & is_last_idx;
        end
    end

`ifdef USBFS_ENDP_RX_BUF_ZLP_EN
    logic zlp_d_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            zlp_d_reg <= 1'b0;
        end else begin
            zlp_d_reg <= er_accepted && (i_erRdNBytes == '0);
        end
    end

    assign push       = rd_en_d_reg | zlp_d_reg;
    assign push_entry = zlp_d_reg ? {1'b1, 1'b1, 8'h00} : {1'b0, last_d_reg, i_erRdByte};
    assign o_zlp      = o_valid & head[9];
`else
    assign push       = rd_en_d_reg;
    assign push_entry = {last_d_reg, i_erRdByte};
    assign o_zlp      = 1'b0;
`endif

    assign pop = i_ready & o_valid;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + CNT_W'(1);
                2'b01:   cnt_reg <= cnt_reg - CNT_W'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    assign head = mem[rd_ptr_reg];

    assign o_valid   = (cnt_reg != '0);
    assign o_data    = o_valid ? head[7:0] : 8'h00;
    assign o_last    = o_valid & head[8];
    assign o_erStall = halt_reg;
    assign o_erReady = er_ready;
    assign o_erRdEn  = rd_en;
    assign o_erRdIdx = (state_reg == ST_READ) ? rd_idx_reg : '0;

    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(push && (cnt_reg == CNT_W'(DEPTH))));
    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        !(pop && (cnt_reg == '0)));

endmodule
